neuron_fire_unit: RTL and testbench
===================================

# neuron_fire_unit

Sequential consumer of the registered adder outputs: accumulates per-time-step synaptic increments (`ADD_OUT_WIDTH` wide) over one gamma window and detects the first threshold crossing. It emits the spike time through a valid/ready handshake to the winner-take-all / output stage. One instance per neuron column, downstream of the adder tree.

## Interface
- data_in_width, `ADD_OUT_WIDTH: width of increments, threshold and accumulator.
- TIME_WIDTH, 4: width of the spike-time counter.
- WINDOW, 16: time steps per gamma window; legal range 1..2^TIME_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a new window; sampled only in IDLE.
- threshold  in  data_in_width  firing threshold (unsigned); latched on accepted start.
- in_valid  in  1  increment present this time step.
- in_data  in  data_in_width  unsigned increment (adder_out).
- busy  out  1  high in ACCUM and HOLD.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- spike_fired  out  1  1 = threshold crossed in window.
- spike_time  out  TIME_WIDTH  step of crossing; all ones when not fired.

## Operation
- States: IDLE, ACCUM, HOLD. Reset → IDLE, acc=0, t=0, thr=0, busy=0, out_valid=0, spike_fired=0, spike_time=0.
- IDLE: start=1 → thr←threshold, acc←0, t←0, go ACCUM. Otherwise hold.
- ACCUM:
  - One cycle = one time step; t advances every cycle regardless of in_valid.
  - acc_next = acc + (in_valid ? in_data : 0), computed at data_in_width+1 bits and saturated to all ones.
  - If acc_next ≥ thr: spike_fired←1, spike_time←t, go HOLD.
  - Else if t == WINDOW-1: spike_fired←0, spike_time←all ones, go HOLD.
  - Else acc←acc_next, t←t+1.
  - Crossing on the last step counts as fired; fired takes priority over the timeout.
- HOLD:
  - out_valid=1; spike_fired and spike_time stay stable.
  - out_ready=1 → out_valid←0, go IDLE.
- start is ignored in ACCUM and HOLD; no queuing.
- thr=0: fires at t=0 even with in_valid=0.
- in_valid/in_data are ignored outside ACCUM.
- threshold changes after start have no effect.
- Reset mid-window or mid-HOLD: immediate return to the reset state; the result is lost.

## Timing
- start high in IDLE at edge E0 → ACCUM from cycle after E0. The input sampled at the k-th ACCUM edge (k=0..) is time step k.
- Crossing at step k → out_valid high the cycle after that edge: start-to-out_valid latency k+2 cycles.
- No-fire window: out_valid after WINDOW+1 cycles from start.
- Handshake completes on an edge with out_valid & out_ready. out_ready high on the first HOLD cycle → out_valid lasts exactly one cycle.
- Earliest next start is sampled in the cycle after handshake (IDLE). Back-to-back throughput: one window per k+3 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst_n=0 mid-ACCUM → all outputs 0 and state IDLE asynchronously; after release, start works normally.
- Basic fire: thr=10, in_data=3 every step, out_ready=1 → crossing at step 3 (acc 12), spike_fired=1, spike_time=3, out_valid 5 cycles after start, one cycle wide.
- No fire / gaps: thr=100, in_data=5 with in_valid on even steps only, WINDOW=16 → spike_fired=0, spike_time=15, out_valid after 17 cycles.
- Boundary: thr=0 → spike_time=0 with in_valid=0. Separately, exact crossing on step WINDOW-1 (thr=16, in_data=1 every step) → spike_fired=1, spike_time=15.
- Saturation: data_in_width=8, thr=255, in_data=200 each step → acc saturates at 255, fires at step 1. No wrap: acc never reads 144.
- Backpressure and ignored inputs: out_ready=0 for 5 cycles → out_valid and outputs stable. Pulses of start and threshold changes during ACCUM and HOLD → no effect. Release out_ready → one handshake, then a new start is accepted.

Source files
------------

// File: rtl/neuron_fire_unit.sv
// neuron_fire_unit
// Accumulates per-time-step synaptic increments over one gamma window and
// reports the first time step at which the accumulator reaches the latched
// threshold. The result is held on a valid/ready interface until it is taken.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        begin a new window (sampled only when idle)
//   threshold    firing threshold, latched on accepted start
//   in_valid     increment present this time step
//   in_data      unsigned increment from the adder tree
//   busy         high while accumulating or holding a result
//   out_valid    result available
//   out_ready    downstream accepts the result
//   spike_fired  1 = threshold crossed inside the window
//   spike_time   step of the crossing; all ones when not fired
module neuron_fire_unit #(
    parameter int unsigned data_in_width = 8,
    parameter int unsigned TIME_WIDTH    = 4,
    parameter int unsigned WINDOW        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [data_in_width-1:0] threshold,
    input  logic                     in_valid,
    input  logic [data_in_width-1:0] in_data,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     spike_fired,
    output logic [TIME_WIDTH-1:0]    spike_time
);

    localparam int unsigned SUM_W = data_in_width + 1;
    localparam logic [TIME_WIDTH-1:0] LAST_STEP = TIME_WIDTH'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                   state,        state_nxt;
    logic [data_in_width-1:0] acc,          acc_nxt;
    logic [data_in_width-1:0] thr,          thr_nxt;
    logic [TIME_WIDTH-1:0]    t,            t_nxt;
    logic                     busy_nxt;
    logic                     out_valid_nxt;
    logic                     spike_fired_nxt;
    logic [TIME_WIDTH-1:0]    spike_time_nxt;

    logic [data_in_width-1:0] inc;
    logic [SUM_W-1:0]         sum;
    logic [data_in_width-1:0] acc_sat;

    // Saturating accumulate: one spare bit catches the carry, which clamps to all ones.
    always_comb begin
        inc     = in_valid ? in_data : '0;
        sum     = SUM_W'(acc) + SUM_W'(inc);
        acc_sat = sum[SUM_W-1] ? '1 : sum[data_in_width-1:0];
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            thr         <= '0;
            t           <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            spike_fired <= 1'b0;
            spike_time  <= '0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            thr         <= thr_nxt;
            t           <= t_nxt;
            busy        <= busy_nxt;
            out_valid   <= out_valid_nxt;
            spike_fired <= spike_fired_nxt;
            spike_time  <= spike_time_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        acc_nxt         = acc;
        thr_nxt         = thr;
        t_nxt           = t;
        busy_nxt        = busy;
        out_valid_nxt   = out_valid;
        spike_fired_nxt = spike_fired;
        spike_time_nxt  = spike_time;

        case (state)
            IDLE: begin
                if (start) begin
                    thr_nxt   = threshold;
                    acc_nxt   = '0;
                    t_nxt     = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = ACCUM;
                end
            end

            ACCUM: begin
                // A crossing on the last step wins over the window timeout.
                if (acc_sat >= thr) begin
                    spike_fired_nxt = 1'b1;
                    spike_time_nxt  = t;
                    out_valid_nxt   = 1'b1;
                    state_nxt       = HOLD;
                end else if (t == LAST_STEP) begin
                    spike_fired_nxt = 1'b0;
                    spike_time_nxt  = '1;
                    out_valid_nxt   = 1'b1;
                    state_nxt       = HOLD;
                end else begin
                    acc_nxt = acc_sat;
                    t_nxt   = t + TIME_WIDTH'(1);
                end
            end

            HOLD: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                out_valid_nxt = 1'b0;
                busy_nxt      = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_neuron_fire_unit.sv
// Testbench for neuron_fire_unit: directed windows, expected results queued
// by the driver and checked by an independent monitor on the falling edge.
module tb_neuron_fire_unit;

    localparam int unsigned DW  = 8;
    localparam int unsigned TW  = 4;
    localparam int unsigned WIN = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] threshold;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic          spike_fired;
    logic [TW-1:0] spike_time;

    neuron_fire_unit #(
        .data_in_width (DW),
        .TIME_WIDTH    (TW),
        .WINDOW        (WIN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .threshold   (threshold),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .spike_fired (spike_fired),
        .spike_time  (spike_time)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fired;
        logic [TW-1:0] tm;
        int            lat;
        int            start_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;
    bit   cur_active   = 1'b0;
    bit   hs_prev      = 1'b0;
    bit   drv_timeout  = 1'b0;
    bit   timeout_seen = 1'b0;
    bit   done         = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Monitor: checks reset values, pops one expectation per result, checks stability and handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_spike_fired", int'(spike_fired), 0);
            chk("rst_spike_time", int'(spike_time), 0);
            cur_active = 1'b0;
            hs_prev    = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("post_hs_out_valid", int'(out_valid), 0);
                chk("post_hs_busy", int'(busy), 0);
                cur_active = 1'b0;
            end
            if (out_valid) begin
                chk("busy_in_hold", int'(busy), 1);
                if (!cur_active) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got fired=%0d time=%0d want none",
                                 spike_fired, spike_time);
                    end else begin
                        cur        = exp_q.pop_front();
                        cur_active = 1'b1;
                        chk("spike_fired", int'(spike_fired), int'(cur.fired));
                        chk("spike_time", int'(spike_time), int'(cur.tm));
                        chk("latency", cycle - cur.start_cyc + 1, cur.lat);
                    end
                end else begin
                    chk("hold_spike_fired", int'(spike_fired), int'(cur.fired));
                    chk("hold_spike_time", int'(spike_time), int'(cur.tm));
                end
            end
            hs_prev = out_valid && out_ready;
        end

        if (drv_timeout && !timeout_seen) begin
            timeout_seen = 1'b1;
            total++;
            bad++;
            $display("FAIL driver_timeout: got no handshake want handshake within 40 cycles");
        end

        if (done || cycle > 20000) begin
            if (!done) begin
                total++;
                bad++;
                $display("FAIL watchdog: got cycle %0d want done", cycle);
            end
            chk("leftover_expectations", exp_q.size(), 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // Run one window. mode: 0 = in_valid every step, 1 = even steps only, 2 = never.
    task automatic run_window(input logic [DW-1:0] thr, input logic [DW-1:0] data,
                              input int mode, input logic ef, input logic [TW-1:0] et,
                              input int el, input int stall, input bit noise);
        exp_t e;
        int   n;
        out_ready = (stall == 0);
        start     = 1'b1;
        threshold = thr;
        @(posedge clk); #1;
        start       = 1'b0;
        e.fired     = ef;
        e.tm        = et;
        e.lat       = el;
        e.start_cyc = cycle;
        exp_q.push_back(e);

        n = 0;
        while (!out_valid && n < 40) begin
            in_valid = (mode == 0) || (mode == 1 && (n % 2) == 0);
            in_data  = data;
            if (noise) begin
                start     = n[0];
                threshold = DW'(n);
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (!out_valid) drv_timeout = 1'b1;

        for (int i = 0; i < stall; i++) begin
            if (noise) begin
                start     = i[0] ? 1'b0 : 1'b1;
                threshold = DW'(8'hF0 + i);
                in_valid  = 1'b1;
                in_data   = 8'hFF;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        n = 0;
        while (out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid) drv_timeout = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        threshold = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic fire: 3,6,9,12 -> crosses 10 at step 3.
        run_window(8'd10, 8'd3, 0, 1'b1, 4'd3, 5, 0, 1'b0);

        // Reset in the middle of a window; result is dropped, outputs clear asynchronously.
        start     = 1'b1;
        threshold = 8'd100;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd5;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Start works normally after reset.
        run_window(8'd10, 8'd3, 0, 1'b1, 4'd3, 5, 0, 1'b0);
        // No fire: 8 even steps x 5 = 40 < 100.
        run_window(8'd100, 8'd5, 1, 1'b0, 4'hF, WIN + 1, 0, 1'b0);
        // Zero threshold fires at step 0 without any input.
        run_window(8'd0, 8'd0, 2, 1'b1, 4'd0, 2, 0, 1'b0);
        // Exact crossing on the last step.
        run_window(8'd16, 8'd1, 0, 1'b1, 4'd15, WIN + 1, 0, 1'b0);
        // Saturation: 200 then clamp to 255 (wrap would give 144 and miss).
        run_window(8'd255, 8'd200, 0, 1'b1, 4'd1, 3, 0, 1'b0);
        // Backpressure with start/threshold noise during ACCUM and HOLD.
        run_window(8'd10, 8'd3, 0, 1'b1, 4'd3, 5, 5, 1'b1);
        // Immediate new start after the handshake: 2,4 -> crosses 4 at step 1.
        run_window(8'd4, 8'd2, 0, 1'b1, 4'd1, 3, 0, 1'b0);

        repeat (2) @(posedge clk);
        done = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL monitor_stalled: got no summary want summary");
        $fatal(1);
    end

endmodule
